frog_ctrl: RTL and testbench
============================

FROG_CTRL -- requirements
Module: frog_ctrl

Interface
REQ-001 Parameter N, default 8, meaning LFSR width of the driven frog_chip.
REQ-002 Parameter GAP, default 5, meaning idle cycles between end of load and start of test.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to run one program/seed/test sequence.
REQ-006 abort  input  1  cancel the sequence in progress.
REQ-007 cfg_taps  input  N  tap program, bit i sent on load cycle i.
REQ-008 cfg_seed  input  N  seed, bit i sent on load cycle i.
REQ-009 cfg_len  input  8  number of test cycles (0..255).
REQ-010 chip_load  output  1  drives frog_chip load.
REQ-011 chip_program  output  1  drives frog_chip program.
REQ-012 chip_seed  output  1  drives frog_chip seed.
REQ-013 chip_test  output  1  drives frog_chip test.
REQ-014 chip_out  input  1  frog_chip out.
REQ-015 busy  output  1  high in LOAD, GAP, TEST.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 result  output  N  last N captured chip_out bits.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, GAP, TEST, DONE; all outputs registered.
REQ-019 In IDLE, start=1 and abort=0 SHALL latch cfg_taps, cfg_seed, cfg_len and enter LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-020 LOAD SHALL last exactly N cycles with chip_load=1 and chip_program/chip_seed = latched bit k on the k-th LOAD cycle (k=0 first, LSB first).
REQ-021 GAP SHALL last exactly GAP cycles with chip_load=0, chip_test=0; GAP=0 SHALL go LOAD->TEST directly.
REQ-022 TEST SHALL last exactly latched cfg_len cycles with chip_test=1; cfg_len=0 SHALL skip TEST (GAP->DONE).
REQ-023 During each TEST cycle the controller SHALL capture chip_out at that cycle's closing edge: result <= {chip_out, result[N-1:1]}.
REQ-024 result SHALL be cleared to 0 on start acceptance and hold its value outside TEST.
REQ-025 cfg_len < N SHALL leave the upper captured bits in result and unfilled low bits 0 per REQ-023/024 shifting.
REQ-026 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE; done SHALL never be high in any other state.
REQ-027 chip_program and chip_seed SHALL be 0 whenever chip_load=0.
REQ-028 abort=1 in LOAD, GAP or TEST SHALL enter IDLE next cycle with all chip_* outputs 0, no done pulse, result holding partial capture.
REQ-029 abort=1 with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-030 Cycle counter SHALL be wide enough for max(N, GAP, 255) and reload to 0 on each state entry.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, counter 0, result 0, latched config 0, and all outputs 0, regardless of state or other inputs.
REQ-032 Reset released mid-sequence SHALL not resume; a new start is required.

Structure
REQ-033 Package frog_pkg SHALL hold the state enum and the default N and GAP constants.
REQ-034 One sub-module frog_piso (N-bit parallel-in serial-out, two lanes for taps and seed) SHALL serialize the load bits; the capture shift register and FSM stay in frog_ctrl.

Verification
REQ-035 Reset then start with taps=8'hB8, seed=8'hAA, len=8 -> chip_load high 8 cycles, program bits 0,0,0,1,1,1,0,1, seed bits 0,1,0,1,0,1,0,1, 5 idle cycles, chip_test high 8 cycles, one done pulse, result matches a frog_chip model.
REQ-036 len=0 -> LOAD 8, GAP 5, then done with chip_test never high and result=0.
REQ-037 abort on 3rd TEST cycle -> IDLE next cycle, chip_test 0, no done, result holds 2 captured bits in [7:6].
REQ-038 start pulsed during LOAD and DONE -> ignored; exactly one sequence and one done pulse.
REQ-039 rst_n low during GAP -> all outputs 0 next cycle, result 0, no done; fresh start runs full sequence.
REQ-040 len=3 with chip_out tied 1 -> result=8'hE0 after done.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared constants for the frog_chip controller: default geometry, state
// encoding and counter sizing.
package frog_pkg;

  localparam int unsigned N_DEFAULT   = 8;
  localparam int unsigned GAP_DEFAULT = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_TEST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The counter must reach the longest of the LOAD, GAP and TEST phases.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned gap);
    int unsigned m;
    m = 255;
    if (n > m) m = n;
    if (gap > m) m = gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frog_piso.sv
// Two-lane parallel-in serial-out register feeding the chip program/seed
// pins LSB first; the lane outputs are registers and drop to 0 when idle.
module frog_piso #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] data_a,
  input  logic [N-1:0] data_b,
  output logic         bit_a,
  output logic         bit_b
);

  logic [N-1:0] sr_a;
  logic [N-1:0] sr_b;

  // Bit 0 goes straight to the output on load, so the shifter holds the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_a  <= '0;
      sr_b  <= '0;
      bit_a <= 1'b0;
      bit_b <= 1'b0;
    end else if (load) begin
      sr_a  <= data_a >> 1;
      sr_b  <= data_b >> 1;
      bit_a <= data_a[0];
      bit_b <= data_b[0];
    end else if (shift) begin
      sr_a  <= sr_a >> 1;
      sr_b  <= sr_b >> 1;
      bit_a <= sr_a[0];
      bit_b <= sr_b[0];
    end else begin
      bit_a <= 1'b0;
      bit_b <= 1'b0;
    end
  end

endmodule

// File: rtl/frog_ctrl.sv
// Sequencer for a frog_chip: serially loads taps and seed, waits GAP cycles,
// runs the chip for cfg_len test cycles and captures its output stream.
module frog_ctrl
  import frog_pkg::*;
#(
  parameter int unsigned N   = N_DEFAULT,
  parameter int unsigned GAP = GAP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] cfg_taps,
  input  logic [N-1:0] cfg_seed,
  input  logic [7:0]   cfg_len,
  output logic         chip_load,
  output logic         chip_program,
  output logic         chip_seed,
  output logic         chip_test,
  input  logic         chip_out,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned    CW        = cnt_width(N, GAP);
  localparam logic [CW-1:0]  LOAD_LAST = CW'(N - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'((GAP == 0) ? 0 : GAP - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [2:0]    after_gap;
  logic [CW-1:0] cnt;
  logic [7:0]    len_q;
  logic          accept;
  logic          load_shift;

  always_comb begin
    accept     = (state == S_IDLE) && start && !abort;
    after_gap  = (len_q == 8'd0) ? S_DONE : S_TEST;
    state_n    = state;
    case (state)
      S_IDLE: if (accept) state_n = S_LOAD;
      S_LOAD: begin
        if (abort) state_n = S_IDLE;
        else if (cnt == LOAD_LAST) state_n = (GAP == 0) ? after_gap : S_GAP;
      end
      S_GAP: begin
        if (abort) state_n = S_IDLE;
        else if (cnt == GAP_LAST) state_n = after_gap;
      end
      S_TEST: begin
        if (abort) state_n = S_IDLE;
        else if (cnt == CW'(len_q - 8'd1)) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    load_shift = (state == S_LOAD) && (state_n == S_LOAD);
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      result    <= '0;
      chip_load <= 1'b0;
      chip_test <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || state_n == S_IDLE) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (accept) len_q <= cfg_len;
      if (accept) result <= '0;
      else if (state == S_TEST && !abort) result <= {chip_out, result[N-1:1]};
      chip_load <= (state_n == S_LOAD);
      chip_test <= (state_n == S_TEST);
      busy      <= (state_n == S_LOAD) || (state_n == S_GAP) || (state_n == S_TEST);
      done      <= (state_n == S_DONE);
    end
  end

  frog_piso #(.N(N)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .shift  (load_shift),
    .data_a (cfg_taps),
    .data_b (cfg_seed),
    .bit_a  (chip_program),
    .bit_b  (chip_seed)
  );

endmodule

// File: tb/tb_frog_ctrl.sv
// Scoreboard bench for frog_ctrl: a driver queues expected sequence records,
// a negedge monitor reconstructs each observed sequence and compares it.
module tb_frog_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned GAP = 5;

  typedef struct {
    int         n_load;
    logic [7:0] prog;
    logic [7:0] seed;
    int         n_gap;
    int         n_test;
    bit         done;
    logic [7:0] result;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_taps = '0;
  logic [7:0] cfg_seed = '0;
  logic [7:0] cfg_len = '0;
  logic       chip_load, chip_program, chip_seed, chip_test, chip_out, busy, done;
  logic [7:0] result;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  frog_ctrl #(.N(N), .GAP(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_taps     (cfg_taps),
    .cfg_seed     (cfg_seed),
    .cfg_len      (cfg_len),
    .chip_load    (chip_load),
    .chip_program (chip_program),
    .chip_seed    (chip_seed),
    .chip_test    (chip_test),
    .chip_out     (chip_out),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  // frog_chip model: serial tap/seed load, Fibonacci LFSR stepping in test.
  logic [7:0] ct = '0;
  logic [7:0] cs = '0;
  bit         ones = 1'b0;
  always @(posedge clk) begin
    if (chip_load === 1'b1) begin
      ct <= {chip_program, ct[7:1]};
      cs <= {chip_seed, cs[7:1]};
    end else if (chip_test === 1'b1) begin
      cs <= {^(cs & ct), cs[7:1]};
    end
  end
  assign chip_out = ones ? 1'b1 : cs[0];

  function automatic logic [7:0] ref_result(input logic [7:0] taps, input logic [7:0] seed,
                                            input int len, input bit one);
    logic [7:0] s;
    logic [7:0] r;
    s = seed;
    r = '0;
    for (int i = 0; i < len; i++) begin
      r = {(one ? 1'b1 : s[0]), r[7:1]};
      s = {^(s & taps), s[7:1]};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  bit         in_seg = 1'b0;
  int         m_load, m_gap, m_test;
  logic [7:0] m_prog, m_seed;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!in_seg) begin
        in_seg = 1'b1;
        m_load = 0; m_gap = 0; m_test = 0;
        m_prog = '0; m_seed = '0;
      end
      chk("load_gating", 32'((chip_program | chip_seed) & ~chip_load), 0);
      chk("done_while_busy", 32'(done), 0);
      if (chip_load) begin
        if (m_load < 8) begin
          m_prog[m_load] = chip_program;
          m_seed[m_load] = chip_seed;
        end
        m_load++;
      end else if (chip_test) m_test++;
      else m_gap++;
    end else if (in_seg) begin
      in_seg = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sequence: got load=%0d test=%0d expected none", m_load, m_test);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("load_cycles", 32'(m_load), 32'(e.n_load));
        chk("program_bits", 32'(m_prog), 32'(e.prog));
        chk("seed_bits", 32'(m_seed), 32'(e.seed));
        chk("gap_cycles", 32'(m_gap), 32'(e.n_gap));
        chk("test_cycles", 32'(m_test), 32'(e.n_test));
        chk("done_pulse", 32'(done), 32'(e.done));
        chk("result", 32'(result), 32'(e.result));
        chk("end_chip_outputs", 32'({chip_load, chip_test, chip_program, chip_seed}), 0);
      end
    end else begin
      chk("idle_outputs", 32'({done, chip_load, chip_test, chip_program, chip_seed}), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] taps, input logic [7:0] seed, input int n_gap,
                          input int n_test, input bit dn, input logic [7:0] res);
    rec_t e;
    e.n_load = N; e.prog = taps; e.seed = seed;
    e.n_gap = n_gap; e.n_test = n_test; e.done = dn; e.result = res;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] taps, input logic [7:0] seed, input logic [7:0] len);
    cfg_taps = taps; cfg_seed = seed; cfg_len = len;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cfg_taps = 8'($urandom); cfg_seed = 8'($urandom); cfg_len = 8'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      cyc();
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    cyc();
  endtask

  task automatic run_seq(input logic [7:0] taps, input logic [7:0] seed, input int len, input bit one);
    ones = one;
    push_exp(taps, seed, GAP, len, 1'b1, ref_result(taps, seed, len, one));
    issue(taps, seed, 8'(len));
    wait_drain();
    ones = 1'b0;
  endtask

  task automatic wait_for(input string name, input bit want_test, input bit want_gap, input bit want_done);
    int  k = 0;
    bit  hit = 1'b0;
    while (!hit && k < 600) begin
      hit = (want_test && chip_test === 1'b1) ||
            (want_gap && busy === 1'b1 && chip_load === 1'b0 && chip_test === 1'b0) ||
            (want_done && done === 1'b1);
      if (!hit) begin
        cyc();
        k++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t, s;
    repeat (3) cyc();
    chk("reset_state", 32'({chip_load, chip_program, chip_seed, chip_test, busy, done, result}), 0);
    rst_n = 1'b1;
    cyc();

    run_seq(8'hB8, 8'hAA, 8, 1'b0);
    run_seq(8'h8E, 8'h5C, 0, 1'b0);

    // abort on the third TEST cycle
    t = 8'hB8; s = 8'h3D;
    push_exp(t, s, GAP, 3, 1'b0, ref_result(t, s, 2, 1'b0));
    issue(t, s, 8'd8);
    wait_for("wait_test", 1'b1, 1'b0, 1'b0);
    cyc(); cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_drain();
    repeat (3) cyc();
    chk("abort_result_hold", 32'(result), 32'(ref_result(t, s, 2, 1'b0)));

    // start pulses during LOAD and DONE are ignored
    t = 8'h1D; s = 8'hC3;
    push_exp(t, s, GAP, 6, 1'b1, ref_result(t, s, 6, 1'b0));
    issue(t, s, 8'd6);
    cfg_len = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_for("wait_done", 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_drain();
    repeat (4) cyc();
    chk("no_restart", 32'(busy), 0);

    // reset during GAP
    t = 8'hE1; s = 8'h7F;
    push_exp(t, s, 2, 0, 1'b0, 8'h00);
    issue(t, s, 8'd8);
    wait_for("wait_gap", 1'b0, 1'b1, 1'b0);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("reset_mid_outputs", 32'({chip_load, chip_program, chip_seed, chip_test, busy, done, result}), 0);
    rst_n = 1'b1;
    wait_drain();
    repeat (3) cyc();
    chk("no_resume", 32'(busy), 0);
    run_seq(8'hB8, 8'hAA, 8, 1'b0);

    run_seq(8'($urandom), 8'($urandom), 3, 1'b1);
    chk("len3_ones", 32'(result), 32'h0000_00E0);

    // start with abort in IDLE
    cfg_len = 8'd4;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    repeat (3) cyc();
    chk("start_abort_idle", 32'(busy), 0);

    run_seq(8'($urandom), 8'($urandom), 255, 1'b0);
    for (int i = 0; i < 12; i++) begin
      int len;
      len = (i % 4 == 0) ? 0 : int'($urandom_range(1, 20));
      run_seq(8'($urandom), 8'($urandom), len, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) cyc();
    end

    repeat (5) cyc();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
